multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style FSM controller for the next-generation multicycle RV32I datapath. It replaces the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles.
- Drives shared ALU, memory and register-file muxes, honours a memory-ready handshake, and flags illegal opcodes.
- Sits between the instruction register and the datapath, in the core top.

Parameters:
- ENABLE_SHIFTS, 1, 1 = decode SLL/SRL/SRA(I/R); 0 = these funct3 values are illegal.
- MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready ignored and treated as 1.
- ALU_CTRL_W, 4, alu_control width; must be >= 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  load PC from result bus.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  latch instruction and oldPC.
- reg_write  out  1  register-file write.
- result_src  out  2  result bus: 00 = ALUOut, 01 = MemData, 10 = ALUResult(PC+4 path), 11 = ALUResult.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
- alu_control  out  ALU_CTRL_W  ALU operation.
- illegal_instr  out  1  sticky illegal-instruction flag.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (asynchronous) forces state = FETCH and illegal_instr = 0. All outputs are decoded from state, so reset mid-operation drops mem_write/reg_write in the same instant.
- Outputs not listed for a state are 0. alu_control defaults to ADD.
- FETCH (0):
  - adr_src=0, mem_read=1, a=PC, b=4, result_src=10.
  - When mem_ready: ir_write=1, pc_write=1, next = DECODE. Otherwise stay in FETCH with ir_write and pc_write at 0.
- DECODE (1): a=oldPC, b=imm, ADD (branch/JAL target lands in ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 or 0010111 -> EXECU.
  - 1110011 -> FETCH (NOP).
  - anything else -> TRAP.
- MEMADR (2): a=rs1, b=imm, ADD. Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD (3): adr_src=1, mem_read=1. Hold until mem_ready, then -> MEMWB.
- MEMWB (4): result_src=01, reg_write=1 -> FETCH.
- MEMWRITE (5): adr_src=1, mem_write=1 held stable until mem_ready, then -> FETCH.
- EXECR (6): a=rs1, b=rs2, -> ALUWB. ALU op by funct3:
  - 000: SUB if funct7b5, else ADD.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU.
  - 001 SLL; 101 SRA if funct7b5, else SRL.
- EXECI (7): a=rs1, b=imm, -> ALUWB. Same funct3 map as EXECR except:
  - 000 is always ADD.
  - funct7b5 selects SRA only when funct3 = 101.
- Illegal decode in EXECR/EXECI:
  - Shift funct3 (001/101) with ENABLE_SHIFTS=0 -> TRAP instead of ALUWB.
  - R-type funct3=000 with funct7b5 never traps.
- EXECU (8): a = 11 (zero) for LUI or 01 (oldPC) for AUIPC, b=imm, ADD -> ALUWB.
- ALUWB (9): result_src=00, reg_write=1 -> FETCH.
- BRANCH (10): a=rs1, b=rs2, SUB, result_src=00.
  - Taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - pc_write = taken.
  - funct3 010/011 -> TRAP without pc_write.
  - Next = FETCH.
- JAL (11): a=oldPC, b=4, ADD, result_src=00, pc_write=1 -> ALUWB (writes PC+4).
- JALR (12): a=rs1, b=imm, ADD, result_src=11, pc_write=1 -> JALWB.
- JALWB (13): a=oldPC, b=4, ADD, result_src=11, reg_write=1 -> FETCH.
- TRAP (14): all enables 0, illegal_instr set to 1. Stays in TRAP until reset.
- Unused encoding 15 -> FETCH next cycle.
- MEM_WAIT=0: every memory state advances after exactly one cycle.
- Latencies with zero wait states:
  - Load 5 cycles.
  - Store 4.
  - R/I/U 4.
  - Branch 3.
  - JAL 4.
  - JALR 4.
  - ECALL/EBREAK 2.

Decomposition:
- Package riscv_ctrl_pkg, shared with datapath and ALU:
  - State enum.
  - Opcode constants.
  - ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
  - Mux select constants.
- One sub-module, alu_decoder: combinational mapping (opcode class, funct3, funct7b5, ENABLE_SHIFTS) -> alu_control plus illegal bit. Instantiated once.

Test Plan:
- Reset during MEMWRITE with mem_ready=0: assert reset -> mem_write falls immediately, state_o=0, illegal_instr=0.
- lw with mem_ready low for 2 cycles in MEMREAD -> stays in MEMREAD (3); reg_write pulses exactly once in MEMWB; total 7 cycles FETCH-to-FETCH.
- beq with zero=1 -> pc_write=1 in BRANCH, result_src=00. Repeat with zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- sub (0110011, f3=000, f7b5=1) -> alu_control=1 in EXECR. addi with f7b5=1 -> alu_control=0.
- ENABLE_SHIFTS=0, slli -> TRAP, illegal_instr=1, no reg_write. illegal_instr stays high for 10 further cycles; clears only on reset.
- jalr -> JALR: pc_write=1, result_src=11, a=10. JALWB: reg_write=1, a=01, b=10. Then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Control-path definitions shared by the multicycle controller, datapath and ALU:
// FSM states, opcode constants, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StExecU    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StJalr     = 4'd12,
    StJalWb    = 4'd13,
    StTrap     = 4'd14,
    StUnused   = 4'd15
  } state_e;

  // Which decode table the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    AluClsAdd,
    AluClsR,
    AluClsI,
    AluClsBranch
  } alu_cls_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResPc4       = 2'b10;
  localparam logic [1:0] ResAluResult = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps (decode class, funct3, funct7b5) to an ALU operation and flags encodings
// the core does not implement.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_SHIFTS = 1'b1
) (
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = AluAdd;
    illegal_o = 1'b0;
    if (cls_i == AluClsBranch) begin
      alu_op_o  = AluSub;
      illegal_o = (funct3_i[2:1] == 2'b01);
    end else if (cls_i == AluClsR || cls_i == AluClsI) begin
      case (funct3_i)
        // Immediate forms have no SUBI: funct7b5 there is an immediate bit.
        3'b000: alu_op_o = (cls_i == AluClsR && funct7b5_i) ? AluSub : AluAdd;
        3'b001: begin
          alu_op_o  = AluSll;
          illegal_o = ~ENABLE_SHIFTS;
        end
        3'b010: alu_op_o = AluSlt;
        3'b011: alu_op_o = AluSltu;
        3'b100: alu_op_o = AluXor;
        3'b101: begin
          alu_op_o  = funct7b5_i ? AluSra : AluSrl;
          illegal_o = ~ENABLE_SHIFTS;
        end
        3'b110: alu_op_o = AluOr;
        3'b111: alu_op_o = AluAnd;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions through fetch/decode/execute/memory/writeback
// and driving the shared datapath muxes of the multicycle core.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit          ENABLE_SHIFTS = 1'b1,
  parameter bit          MEM_WAIT      = 1'b1,
  parameter int unsigned ALU_CTRL_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_instr,
  output logic [3:0]            state_o
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       ready;
  logic       taken;
  alu_cls_e   alu_cls;
  logic [3:0] alu_op;
  logic       op_illegal;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  always_comb begin
    case (state_q)
      StExecR:  alu_cls = AluClsR;
      StExecI:  alu_cls = AluClsI;
      StBranch: alu_cls = AluClsBranch;
      default:  alu_cls = AluClsAdd;
    endcase
  end

  alu_decoder #(
    .ENABLE_SHIFTS(ENABLE_SHIFTS)
  ) u_alu_decoder (
    .cls_i     (alu_cls),
    .funct3_i  (funct3),
    .funct7b5_i(funct7b5),
    .alu_op_o  (alu_op),
    .illegal_o (op_illegal)
  );

  assign alu_control = ALU_CTRL_W'(alu_op);

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    case (state_q)
      StFetch: begin
        mem_read   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResPc4;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Branch/JAL target is precomputed here into ALUOut.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui, OpAuipc:  state_d = StExecU;
          OpSystem:        state_d = StFetch;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResMemData;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        state_d   = op_illegal ? StTrap : StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = op_illegal ? StTrap : StAluWb;
      end
      StExecU: begin
        alu_src_a = (opcode == OpLui) ? SrcAZero : SrcAOldPc;
        alu_src_b = SrcBImm;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = SrcARs1;
        pc_write  = taken & ~op_illegal;
        state_d   = op_illegal ? StTrap : StFetch;
      end
      StJal: begin
        // PC <- ALUOut (target); ALUWB then writes oldPC+4 to rd.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a  = SrcARs1;
        alu_src_b  = SrcBImm;
        result_src = ResAluResult;
        pc_write   = 1'b1;
        state_d    = StJalWb;
      end
      StJalWb: begin
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Flag rises in the same cycle the FSM lands in TRAP.
  assign illegal_d = illegal_q | (state_d == StTrap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized instruction
// streams checked against a per-instruction state-path and output-table model.
module tb_multicycle_control_unit;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst_a, rst_b, mr_a, mr_b;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic f7b5, zero, lt, ltu;
  // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src, a, b, alu, illegal}
  wire [16:0] bun_a, bun_b;
  wire [3:0]  st_a, st_b;

  int errors = 0;
  int checks = 0;
  int path_q[$];
  bit rdy_q[$];
  logic [16:0] snap [16];
  int snap_n [16];
  int cyc, rw_cnt;

  always #5 clk = ~clk;

  multicycle_control_unit dut_a (
    .clk(clk), .reset(rst_a), .opcode(opcode), .funct3(funct3), .funct7b5(f7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mr_a),
    .pc_write(bun_a[16]), .adr_src(bun_a[15]), .mem_read(bun_a[14]), .mem_write(bun_a[13]),
    .ir_write(bun_a[12]), .reg_write(bun_a[11]), .result_src(bun_a[10:9]),
    .alu_src_a(bun_a[8:7]), .alu_src_b(bun_a[6:5]), .alu_control(bun_a[4:1]),
    .illegal_instr(bun_a[0]), .state_o(st_a)
  );

  multicycle_control_unit #(.ENABLE_SHIFTS(1'b0), .MEM_WAIT(1'b0), .ALU_CTRL_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(opcode), .funct3(funct3), .funct7b5(f7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mr_b),
    .pc_write(bun_b[16]), .adr_src(bun_b[15]), .mem_read(bun_b[14]), .mem_write(bun_b[13]),
    .ir_write(bun_b[12]), .reg_write(bun_b[11]), .result_src(bun_b[10:9]),
    .alu_src_a(bun_b[8:7]), .alu_src_b(bun_b[6:5]), .alu_control(bun_b[4:1]),
    .illegal_instr(bun_b[0]), .state_o(st_b)
  );

  function automatic logic [3:0] alu_ref(bit is_r);
    case (funct3)
      3'b000:  return (is_r && f7b5) ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return f7b5 ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic branch_taken();
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output bundle for a state number, straight from the per-state output table.
  function automatic logic [16:0] exp_out(int st, bit rdy);
    logic pw = 0, adr = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0;
    logic [3:0] alu = 0;
    case (st)
      0:  begin mrd = 1; b = 2'b10; res = 2'b10; pw = rdy; irw = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin adr = 1; mrd = 1; end
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mwr = 1; end
      6:  begin a = 2'b10; alu = alu_ref(1'b1); end
      7:  begin a = 2'b10; b = 2'b01; alu = alu_ref(1'b0); end
      8:  begin a = (opcode == LUI) ? 2'b11 : 2'b01; b = 2'b01; end
      9:  rw = 1;
      10: begin a = 2'b10; alu = 4'd1; pw = branch_taken(); end
      11: begin a = 2'b01; b = 2'b10; pw = 1; end
      12: begin a = 2'b10; b = 2'b01; res = 2'b11; pw = 1; end
      13: begin a = 2'b01; b = 2'b10; res = 2'b11; rw = 1; end
      14: ill = 1;
      default: ;
    endcase
    return {pw, adr, mrd, mwr, irw, rw, res, a, b, alu, ill};
  endfunction

  function automatic bit is_known(logic [6:0] op);
    return op inside {LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
  endfunction

  task automatic add(int s, bit r);
    path_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  // Expected state sequence of one instruction on the MEM_WAIT=1, shifts-enabled unit.
  task automatic build_path(int wf, int wm);
    path_q.delete();
    rdy_q.delete();
    repeat (wf) add(0, 1'b0);
    add(0, 1'b1);
    add(1, 1'($urandom_range(0, 1)));
    case (opcode)
      LOAD:  begin add(2, 1'b1); repeat (wm) add(3, 1'b0); add(3, 1'b1); add(4, 1'b0); end
      STORE: begin add(2, 1'b0); repeat (wm) add(5, 1'b0); add(5, 1'b1); end
      RTYPE: begin add(6, 1'b1); add(9, 1'b0); end
      ITYPE: begin add(7, 1'b0); add(9, 1'b1); end
      LUI, AUIPC: begin add(8, 1'b1); add(9, 1'b1); end
      BRANCH: begin add(10, 1'b1); if (funct3[2:1] == 2'b01) add(14, 1'b1); end
      JAL:    begin add(11, 1'b1); add(9, 1'b0); end
      JALR:   begin add(12, 1'b0); add(13, 1'b1); end
      SYSTEM: ;
      default: add(14, 1'b0);
    endcase
  endtask

  // Runs an instruction on dut_a with mem_ready low for `stall` cycles in a memory state.
  task automatic drive_instr(int stall);
    int left = stall;
    foreach (snap_n[i]) snap_n[i] = 0;
    cyc = 0;
    rw_cnt = 0;
    do begin
      if ((st_a == 4'd3 || st_a == 4'd5) && left > 0) begin
        mr_a = 1'b0;
        left--;
      end else mr_a = 1'b1;
      #1;
      snap[st_a] = bun_a;
      snap_n[st_a]++;
      if (bun_a[11]) rw_cnt++;
      @(negedge clk);
      cyc++;
    end while (st_a !== 4'd0 && st_a !== 4'd14 && cyc < 20);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (st_a !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st_a); end
    checks++;
    if (bun_a !== exp_out(0, 1'b0)) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", bun_a, exp_out(0, 1'b0));
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    opcode = STORE;
    mr_a = 1'b1;
    @(negedge clk);
    mr_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (st_a !== 4'd5 || bun_a[13] !== 1'b1) begin
      errors++; $display("FAIL memwrite_entry: got st=%0d mw=%b want st=5 mw=1", st_a, bun_a[13]);
    end
    #1 rst_a = 1'b1;
    #1;
    checks++;
    if (bun_a[13] !== 1'b0 || st_a !== 4'd0 || bun_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_store: got mw=%b st=%0d ill=%b want 0/0/0", bun_a[13], st_a, bun_a[0]);
    end
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_load_wait();
    opcode = LOAD;
    drive_instr(2);
    checks++;
    if (cyc !== 7) begin errors++; $display("FAIL lw_latency: got %0d want 7", cyc); end
    checks++;
    if (snap_n[3] !== 3) begin errors++; $display("FAIL lw_memread_hold: got %0d want 3", snap_n[3]); end
    checks++;
    if (rw_cnt !== 1 || snap[4][11] !== 1'b1) begin
      errors++; $display("FAIL lw_reg_write: got %0d pulses want 1", rw_cnt);
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      opcode = BRANCH;
      funct3 = 3'b000;
      zero = 1'(z);
      drive_instr(0);
      checks++;
      if (snap[10][16] !== 1'(z) || snap[10][10:9] !== 2'b00 || snap[10][4:1] !== 4'd1) begin
        errors++;
        $display("FAIL beq_zero%0d: got pw=%b res=%b alu=%0d want pw=%0d res=00 alu=1",
                 z, snap[10][16], snap[10][10:9], snap[10][4:1], z);
      end
      checks++;
      if (cyc !== 3 || st_a !== 4'd0) begin
        errors++; $display("FAIL beq_latency%0d: got %0d want 3", z, cyc);
      end
    end
  endtask

  task automatic test_alu();
    opcode = RTYPE; funct3 = 3'b000; f7b5 = 1'b1;
    drive_instr(0);
    checks++;
    if (snap_n[6] !== 1 || snap[6][4:1] !== 4'd1) begin
      errors++; $display("FAIL sub_alu: got %0d want 1", snap[6][4:1]);
    end
    opcode = ITYPE;
    drive_instr(0);
    checks++;
    if (snap_n[7] !== 1 || snap[7][4:1] !== 4'd0) begin
      errors++; $display("FAIL addi_f7b5_alu: got %0d want 0", snap[7][4:1]);
    end
    funct3 = 3'b101;
    drive_instr(0);
    checks++;
    if (snap[7][4:1] !== 4'd9 || cyc !== 4) begin
      errors++; $display("FAIL srai_alu: got %0d cyc=%0d want 9 cyc=4", snap[7][4:1], cyc);
    end
  endtask

  task automatic test_jalr();
    opcode = JALR;
    drive_instr(0);
    checks++;
    if (snap[12][16] !== 1'b1 || snap[12][10:9] !== 2'b11 || snap[12][8:7] !== 2'b10) begin
      errors++; $display("FAIL jalr_state: got %h want pw=1 res=11 a=10", snap[12]);
    end
    checks++;
    if (snap[13][11] !== 1'b1 || snap[13][8:7] !== 2'b01 || snap[13][6:5] !== 2'b10) begin
      errors++; $display("FAIL jalwb_state: got %h want rw=1 a=01 b=10", snap[13]);
    end
    checks++;
    if (cyc !== 4 || st_a !== 4'd0) begin errors++; $display("FAIL jalr_latency: got %0d want 4", cyc); end
  endtask

  task automatic test_shift_trap();
    int exp_st [4] = '{0, 1, 7, 14};
    rst_b = 1'b1;
    opcode = LOAD;
    mr_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (st_b !== 4'd0 && cyc < 20);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL nowait_lw_latency: got %0d want 5", cyc); end
    opcode = ITYPE; funct3 = 3'b001; f7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (st_b !== 4'(exp_st[i]) || bun_b[11] !== 1'b0 || bun_b[0] !== (i == 3)) begin
        errors++;
        $display("FAIL slli_trap[%0d]: got st=%0d rw=%b ill=%b want st=%0d rw=0 ill=%0d",
                 i, st_b, bun_b[11], bun_b[0], exp_st[i], i == 3);
      end
      if (i == 0) begin
        checks++;
        if (bun_b[12] !== 1'b1) begin errors++; $display("FAIL nowait_ir_write: got 0 want 1"); end
      end
      @(negedge clk);
    end
    repeat (10) begin
      #1;
      checks++;
      if (st_b !== 4'd14 || bun_b !== 17'h1) begin
        errors++; $display("FAIL trap_sticky: got st=%0d out=%h want st=14 out=00001", st_b, bun_b);
      end
      @(negedge clk);
    end
    rst_b = 1'b1;
    #1;
    checks++;
    if (st_b !== 4'd0 || bun_b[0] !== 1'b0) begin
      errors++; $display("FAIL trap_reset: got st=%0d ill=%b want 0/0", st_b, bun_b[0]);
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_random_back_to_back(int n);
    logic [6:0] ops [10] = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
    bit trapped;
    for (int k = 0; k < n; k++) begin
      int pick = $urandom_range(0, 11);
      if (pick < 10) opcode = ops[pick];
      else do opcode = 7'($urandom); while (is_known(opcode));
      funct3 = 3'($urandom);
      {f7b5, zero, lt, ltu} = 4'($urandom);
      build_path($urandom_range(0, 2), $urandom_range(0, 2));
      trapped = 1'b0;
      foreach (path_q[i]) begin
        mr_a = rdy_q[i];
        #1;
        checks++;
        if (st_a !== 4'(path_q[i]) || bun_a !== exp_out(path_q[i], rdy_q[i])) begin
          errors++;
          $display("FAIL rand[%0d] op=%b f3=%b step %0d: got st=%0d out=%h want st=%0d out=%h",
                   k, opcode, funct3, i, st_a, bun_a, path_q[i], exp_out(path_q[i], rdy_q[i]));
        end
        if (path_q[i] == 14) trapped = 1'b1;
        @(negedge clk);
      end
      #1;
      checks++;
      if (st_a !== (trapped ? 4'd14 : 4'd0)) begin
        errors++; $display("FAIL rand_end[%0d] op=%b: got %0d want %0d", k, opcode, st_a,
                           trapped ? 14 : 0);
      end
      if (trapped) begin
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
      end
    end
    mr_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    opcode = 7'd0; funct3 = 3'd0; f7b5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    mr_a = 1'b0; mr_b = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    test_reset();
    test_load_wait();
    test_branch();
    test_alu();
    test_jalr();
    test_shift_trap();
    test_random_back_to_back(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
